// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: frame-granular round-robin arbiter onto one 8-bit
// AXI-Stream. Over-length frames are cut, closed with tlast and counted.
module net_tx_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   net_axis_clk,
    input  logic                   net_axis_resetn,
    input  logic [8*NUM_PORTS-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]   s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]   s_axis_tlast,
    output logic [NUM_PORTS-1:0]   s_axis_tready,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic [NUM_PORTS-1:0]   grant,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   trunc_count
);
    localparam int IW = $clog2(NUM_PORTS);
    localparam int BW = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(MAX_FRAME_LEN - 1);
    localparam logic [IW-1:0] TOP_PORT = IW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {IDLE, FWD, DRAIN} state_t;

    state_t               state, state_n;
    logic [IW-1:0]        last_grant, last_grant_n;
    logic [NUM_PORTS-1:0] grant_n;
    logic [BW-1:0]        byte_cnt, byte_cnt_n;
    logic [CNT_WIDTH-1:0] trunc_n;
    logic [7:0]           tdata_n;
    logic                 tvalid_n, tlast_n;
    logic [7:0]           in_data;
    logic                 in_last, accept;
    logic [IW-1:0]        pick;
    logic                 pick_ok;
    int                   idx;

    always_comb begin
        in_data = '0;
        in_last = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                in_data = s_axis_tdata[8*i +: 8];
                in_last = s_axis_tlast[i];
            end
        end
    end

    // Only the owner ever sees ready; the output path is a single
    // register so ready follows the downstream ready combinationally.
    always_comb begin
        case (state)
            FWD:     s_axis_tready = grant & {NUM_PORTS{!m_axis_tvalid || m_axis_tready}};
            DRAIN:   s_axis_tready = grant;
            default: s_axis_tready = '0;
        endcase
    end

    assign accept = |(s_axis_tready & s_axis_tvalid);

    // Descending scan so the nearest requester after last_grant wins.
    always_comb begin
        pick    = last_grant;
        pick_ok = 1'b0;
        idx     = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (s_axis_tvalid[IW'(idx)]) begin
                pick    = IW'(idx);
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_n      = grant;
        byte_cnt_n   = byte_cnt;
        trunc_n      = trunc_count;
        tdata_n      = m_axis_tdata;
        tlast_n      = m_axis_tlast;
        tvalid_n     = m_axis_tvalid && !m_axis_tready;
        case (state)
            IDLE: begin
                if (pick_ok) begin
                    state_n       = FWD;
                    last_grant_n  = pick;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    byte_cnt_n    = '0;
                end
            end
            FWD: begin
                if (accept) begin
                    tdata_n    = in_data;
                    tlast_n    = in_last || (byte_cnt == LAST_IDX);
                    tvalid_n   = 1'b1;
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (in_last) begin
                        state_n = IDLE;
                        grant_n = '0;
                    end else if (byte_cnt == LAST_IDX) begin
                        state_n = DRAIN;
                        if (trunc_count != '1) trunc_n = trunc_count + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (accept && in_last) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge net_axis_clk) begin
        if (!net_axis_resetn) begin
            state         <= IDLE;
            last_grant    <= TOP_PORT;
            grant         <= '0;
            byte_cnt      <= '0;
            trunc_count   <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            last_grant    <= last_grant_n;
            grant         <= grant_n;
            byte_cnt      <= byte_cnt_n;
            trunc_count   <= trunc_n;
            m_axis_tdata  <= tdata_n;
            m_axis_tvalid <= tvalid_n;
            m_axis_tlast  <= tlast_n;
            busy          <= (state_n != IDLE);
        end
    end
endmodule

// File: tb/tb_net_tx_arbiter.sv
// Bench for net_tx_arbiter: frame-level round-robin scoreboard plus
// directed latency, fairness, truncation and reset scenarios.
`timescale 1ns/1ps
module tb_net_tx_arbiter;
    localparam int NP   = 4;
    localparam int MAXA = 1518;
    localparam int MAXB = 8;

    typedef struct {
        int         len;
        logic [7:0] base;
    } frame_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        use_b = 1'b0;
    logic        bp = 1'b0;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tlast;
    logic        m_tready;
    logic [3:0]  s_tready, s_tready_a, s_tready_b;
    logic [7:0]  m_tdata, m_tdata_a, m_tdata_b;
    logic        m_tvalid, m_tvalid_a, m_tvalid_b;
    logic        m_tlast, m_tlast_a, m_tlast_b;
    logic [3:0]  grant, grant_a, grant_b;
    logic        busy, busy_a, busy_b;
    logic [15:0] trunc, trunc_a, trunc_b;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [8:0]  src_q[NP][$];
    frame_t      mq[NP][$];
    logic [8:0]  exp_q[$];
    logic [8:0]  out_log[$];
    int          tl_cyc[$];
    logic [3:0]  tl_grant[$];
    int          acc_cnt, first_r2, first_v1, first_mv, stall_cnt, mlg;
    logic [3:0]  first_mv_grant;
    logic [15:0] mtrunc;

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    net_tx_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_LEN(MAXA), .CNT_WIDTH(16)) dut_a (
        .net_axis_clk(clk), .net_axis_resetn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready_a),
        .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a),
        .m_axis_tlast(m_tlast_a), .m_axis_tready(m_tready),
        .grant(grant_a), .busy(busy_a), .trunc_count(trunc_a)
    );

    net_tx_arbiter #(.NUM_PORTS(NP), .MAX_FRAME_LEN(MAXB), .CNT_WIDTH(16)) dut_b (
        .net_axis_clk(clk), .net_axis_resetn(rstn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready_b),
        .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b),
        .m_axis_tlast(m_tlast_b), .m_axis_tready(m_tready),
        .grant(grant_b), .busy(busy_b), .trunc_count(trunc_b)
    );

    assign s_tready = use_b ? s_tready_b : s_tready_a;
    assign m_tdata  = use_b ? m_tdata_b  : m_tdata_a;
    assign m_tvalid = use_b ? m_tvalid_b : m_tvalid_a;
    assign m_tlast  = use_b ? m_tlast_b  : m_tlast_a;
    assign grant    = use_b ? grant_b    : grant_a;
    assign busy     = use_b ? busy_b     : busy_a;
    assign trunc    = use_b ? trunc_b    : trunc_a;

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(int p, int len, logic [7:0] base);
        frame_t f;
        for (int i = 0; i < len; i++)
            src_q[p].push_back({i == len - 1, 8'(base + i)});
        f.len  = len;
        f.base = base;
        mq[p].push_back(f);
    endtask

    // Frame-level reference: round-robin over ports holding whole
    // frames, first MAX bytes of each frame, tlast on the final one.
    function automatic void model_next();
        frame_t f;
        int n, p, mx;
        mx = use_b ? MAXB : MAXA;
        for (int k = 1; k <= NP; k++) begin
            p = (mlg + k) % NP;
            if (mq[p].size() > 0) begin
                f   = mq[p].pop_front();
                mlg = p;
                n   = (f.len > mx) ? mx : f.len;
                for (int i = 0; i < n; i++)
                    exp_q.push_back({i == n - 1, 8'(f.base + i)});
                if (f.len > mx && mtrunc != 16'hFFFF) mtrunc++;
                return;
            end
        end
    endfunction

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            mq[p].delete();
        end
        exp_q.delete();
        out_log.delete();
        tl_cyc.delete();
        tl_grant.delete();
        acc_cnt   = 0;
        first_r2  = -1;
        first_v1  = -1;
        first_mv  = -1;
        stall_cnt = 0;
        mlg       = NP - 1;
        mtrunc    = '0;
    endtask

    task automatic reset_for(int n);
        rstn = 1'b0;
        flush();
        repeat (n) step();
        rstn = 1'b1;
    endtask

    task automatic check_reset(string tag);
        chk({tag, "_mvalid"}, 32'(m_tvalid), 0);
        chk({tag, "_mlast"}, 32'(m_tlast), 0);
        chk({tag, "_mdata"}, 32'(m_tdata), 0);
        chk({tag, "_sready"}, 32'(s_tready), 0);
        chk({tag, "_grant"}, 32'(grant), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_trunc"}, 32'(trunc), 0);
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < NP; p++)
            if (src_q[p].size() != 0 || mq[p].size() != 0) return 1'b0;
        return exp_q.size() == 0;
    endfunction

    task automatic wait_idle(string name);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        while (!done && t < 3000) begin
            step();
            t++;
            done = !busy && !m_tvalid && all_empty();
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%0b pend=%0d, want idle", name, busy, exp_q.size());
        end
    endtask

    task automatic wait_acc(int n);
        int t;
        t = 0;
        while (acc_cnt < n && t < 500) begin
            step();
            t++;
        end
        chk("wait_acc", 32'(acc_cnt >= n), 1);
    endtask

    task automatic wait_out(int n);
        int t;
        t = 0;
        while (out_log.size() < n && t < 500) begin
            step();
            t++;
        end
        chk("wait_out", 32'(out_log.size() >= n), 1);
    endtask

    initial begin
        logic [3:0] hs;
        logic [8:0] w;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        forever begin
            @(negedge clk);
            hs = s_tvalid & s_tready;
            @(posedge clk);
            #1;
            if (rstn)
                for (int p = 0; p < NP; p++)
                    if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() > 0) begin
                    w = src_q[p][0];
                    s_tvalid[p]        = 1'b1;
                    s_tdata[8*p +: 8]  = w[7:0];
                    s_tlast[p]         = w[8];
                end else begin
                    s_tvalid[p]        = 1'b0;
                    s_tdata[8*p +: 8]  = 8'h00;
                    s_tlast[p]         = 1'b0;
                end
            end
            m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic       pstall, plast;
        logic [7:0] pdata;
        logic [8:0] e;
        logic [3:0] acc;
        pstall = 1'b0;
        plast  = 1'b0;
        pdata  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pstall = 1'b0;
            end else begin
                chk("one_ready", 32'($countones(s_tready) <= 1), 1);
                chk("ready_owner", 32'(s_tready & ~grant), 0);
                chk("grant_onehot", 32'($onehot0(grant)), 1);
                chk("busy_grant", 32'(busy), 32'(|grant));
                if (pstall) begin
                    stall_cnt++;
                    chk("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}),
                        32'({1'b1, plast, pdata}));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) model_next();
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL extra_byte: got %0h, want none", {m_tlast, m_tdata});
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", 32'({m_tlast, m_tdata}), 32'(e));
                    end
                    out_log.push_back({m_tlast, m_tdata});
                end
                if (m_tvalid && first_mv < 0) begin
                    first_mv       = cyc;
                    first_mv_grant = grant;
                end
                if (s_tvalid[1] && first_v1 < 0) first_v1 = cyc;
                if (s_tready[2] && first_r2 < 0) first_r2 = cyc;
                acc = s_tvalid & s_tready;
                if (|acc) acc_cnt++;
                if (|(acc & s_tlast)) begin
                    tl_cyc.push_back(cyc);
                    tl_grant.push_back(grant);
                end
                pstall = m_tvalid && !m_tready;
                plast  = m_tlast;
                pdata  = m_tdata;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_for(3);
        check_reset("por");

        send(1, 4, 8'hA0);
        wait_idle("single");
        chk("lat", 32'(first_mv - first_v1), 2);
        chk("lat_grant", 32'(first_mv_grant), 32'h2);
        chk("single_len", 32'(out_log.size()), 4);
        for (int i = 0; i < 4; i++)
            if (i < out_log.size())
                chk("single_byte", 32'(out_log[i]), (i == 3 ? 32'h100 : 0) + 32'hA0 + i);
        chk("single_grant_end", 32'(grant), 0);

        reset_for(1);
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NP; p++)
                send(p, 3, 8'(16 * (4 * k + p)));
        wait_idle("fair");
        chk("fair_frames", 32'(tl_cyc.size()), 8);
        for (int j = 0; j < 8; j++) begin
            if (j < tl_cyc.size()) begin
                if (j > 0) chk("fair_gap", 32'(tl_cyc[j] - tl_cyc[0]), 4 * j);
                chk("fair_grant", 32'(tl_grant[j]), 32'(1 << (j % 4)));
            end
            if (3 * j < out_log.size())
                chk("fair_head", 32'(out_log[3 * j]), 16 * j);
        end

        reset_for(1);
        send(0, 10, 8'h00);
        wait_acc(4);
        send(2, 3, 8'hC0);
        wait_idle("mid");
        chk("mid_frames", 32'(tl_grant.size()), 2);
        if (tl_grant.size() == 2) begin
            chk("mid_g0", 32'(tl_grant[0]), 32'h1);
            chk("mid_g1", 32'(tl_grant[1]), 32'h4);
            chk("mid_ready2", 32'(first_r2), 32'(tl_cyc[0] + 2));
        end
        if (out_log.size() > 10) chk("mid_head2", 32'(out_log[10]), 32'hC0);

        reset_for(1);
        bp = 1'b1;
        send(3, 64, 8'h00);
        wait_idle("bp");
        bp = 1'b0;
        chk("bp_len", 32'(out_log.size()), 64);
        for (int i = 0; i < 64; i++)
            if (i < out_log.size())
                chk("bp_byte", 32'(out_log[i]), (i == 63 ? 32'h100 : 0) + i);
        chk("bp_stalls", 32'(stall_cnt > 0), 1);

        use_b = 1'b1;
        reset_for(1);
        send(3, 12, 8'h30);
        wait_out(4);
        send(0, 3, 8'h50);
        wait_idle("trunc");
        chk("trunc_cnt", 32'(trunc), 1);
        chk("trunc_model", 32'(trunc), 32'(mtrunc));
        chk("trunc_len", 32'(out_log.size()), 11);
        if (out_log.size() == 11) begin
            chk("trunc_last", 32'(out_log[7]), 32'h137);
            chk("trunc_next", 32'(out_log[8]), 32'h50);
            chk("trunc_next_end", 32'(out_log[10]), 32'h152);
        end
        send(1, 8, 8'h70);
        wait_idle("exact");
        chk("exact_cnt", 32'(trunc), 1);
        if (out_log.size() == 19) chk("exact_last", 32'(out_log[18]), 32'h177);
        else chk("exact_len", 32'(out_log.size()), 19);
        send(2, 9, 8'h80);
        wait_idle("over9");
        chk("over9_cnt", 32'(trunc), 2);
        chk("over9_model", 32'(trunc), 32'(mtrunc));
        use_b = 1'b0;

        reset_for(1);
        send(1, 10, 8'h90);
        wait_acc(2);
        reset_for(1);
        check_reset("midrst");
        send(1, 3, 8'hD0);
        send(2, 3, 8'hE0);
        wait_idle("postrst");
        chk("postrst_frames", 32'(tl_grant.size()), 2);
        if (tl_grant.size() == 2) begin
            chk("postrst_g0", 32'(tl_grant[0]), 32'h2);
            chk("postrst_g1", 32'(tl_grant[1]), 32'h4);
        end
        chk("postrst_len", 32'(out_log.size()), 6);
        if (out_log.size() == 6) begin
            chk("postrst_b0", 32'(out_log[0]), 32'hD0);
            chk("postrst_b3", 32'(out_log[3]), 32'hE0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
